divide4_ctrl: RTL and testbench

Sequencing controller for the 8-bit radix-4 SRT divider datapath (`divide4`). Accepts a divide request via a start/ready handshake and registers the operands. Drives the datapath's `state0` load strobe, then counts the iteration cycles. Converts the one-hot signed quotient digits into a binary quotient on the fly, corrects the final remainder sign, and reports the result with a one-cycle `done` pulse.

---
 rtl/divide4_ctrl.sv | 160 ++++++++++++++++
 tb/tb_divide4_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/divide4_ctrl.sv
// Sequencing controller for the radix-4 SRT divider datapath: handshake, load strobe,
// iteration count, on-the-fly quotient conversion and remainder sign correction.
module divide4_ctrl #(
    parameter int unsigned ITER = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      op1,
    input  logic [W-1:0]      op2,
    input  logic [3:0]        qdigit,
    input  logic [10:0]       sum,
    input  logic [10:0]       carry,
    output logic              state0,
    output logic [W-1:0]      dive,
    output logic [W-1:0]      divi,
    output logic              ready,
    output logic              done,
    output logic [2*ITER-1:0] q,
    output logic [10:0]       rem,
    output logic              err
);

    localparam int unsigned QW = 2 * ITER;
    localparam int unsigned RW = 11;
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [QW-1:0]   q_acc;
    logic [QW-1:0]   qm_acc;
    logic [QW-1:0]   q_nxt;
    logic [QW-1:0]   qm_nxt;
    logic            digit_bad;
    logic [RW-1:0]   r_sum;
    logic [RW-1:0]   r_fix;
    logic            bad_divisor;

    // On-the-fly conversion: q_acc holds the digit string value, qm_acc holds value-1
    always_comb begin
        digit_bad = 1'b0;
        q_nxt     = {q_acc[QW-3:0], 2'd0};
        qm_nxt    = {qm_acc[QW-3:0], 2'd3};
        case (qdigit)
            4'b1000: begin
                q_nxt  = {q_acc[QW-3:0], 2'd2};
                qm_nxt = {q_acc[QW-3:0], 2'd1};
            end
            4'b0100: begin
                q_nxt  = {q_acc[QW-3:0], 2'd1};
                qm_nxt = {q_acc[QW-3:0], 2'd0};
            end
            4'b0000: begin
                q_nxt  = {q_acc[QW-3:0], 2'd0};
                qm_nxt = {qm_acc[QW-3:0], 2'd3};
            end
            4'b0010: begin
                q_nxt  = {qm_acc[QW-3:0], 2'd3};
                qm_nxt = {qm_acc[QW-3:0], 2'd2};
            end
            4'b0001: begin
                q_nxt  = {qm_acc[QW-3:0], 2'd2};
                qm_nxt = {qm_acc[QW-3:0], 2'd1};
            end
            default: digit_bad = 1'b1;
        endcase
    end

    // Final remainder from the redundant Sum/Carry pair, with negative-sign correction
    always_comb begin
        r_sum       = sum + carry;
        r_fix       = r_sum + {{(RW-W){1'b0}}, divi};
        bad_divisor = (op2[W-1:W-2] != 2'b01);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            q_acc  <= '0;
            qm_acc <= '0;
            state0 <= 1'b0;
            dive   <= '0;
            divi   <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            q      <= '0;
            rem    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dive   <= op1;
                        divi   <= op2;
                        q_acc  <= '0;
                        qm_acc <= '0;
                        ready  <= 1'b0;
                        if (bad_divisor) begin
                            err   <= 1'b1;
                            q     <= '1;
                            rem   <= {{(RW-W){1'b0}}, op1};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err    <= 1'b0;
                            q      <= '0;
                            rem    <= '0;
                            state0 <= 1'b1;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    state0 <= 1'b0;
                    cnt    <= '0;
                    state  <= S_ITER;
                end
                S_ITER: begin
                    q_acc  <= q_nxt;
                    qm_acc <= qm_nxt;
                    if (digit_bad) begin
                        err <= 1'b1;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_sum[RW-1]) begin
                        q   <= qm_acc;
                        rem <= r_fix;
                    end else begin
                        q   <= q_acc;
                        rem <= r_sum;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide4_ctrl.sv
// Self-checking bench for divide4_ctrl: directed cases plus randomized divides
// compared against an arithmetic model of the quotient digit string.
module tb_divide4_ctrl;

    localparam int unsigned ITER = 4;
    localparam int unsigned W    = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [3:0]  qdigit;
    logic [10:0] sum;
    logic [10:0] carry;
    logic        state0;
    logic [7:0]  dive;
    logic [7:0]  divi;
    logic        ready;
    logic        done;
    logic [7:0]  q;
    logic [10:0] rem;
    logic        err;

    int errors = 0;
    int checks = 0;

    divide4_ctrl #(.ITER(ITER), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .qdigit (qdigit),
        .sum    (sum),
        .carry  (carry),
        .state0 (state0),
        .dive   (dive),
        .divi   (divi),
        .ready  (ready),
        .done   (done),
        .q      (q),
        .rem    (rem),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one divide from an idle negedge; digits are given first-to-last in digs[15:12]..digs[3:0].
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic [15:0] digs,
                           input logic [10:0] s, input logic [10:0] c, input bit noise);
        int          qv;
        int          dd;
        bit          ill;
        bit          good;
        int          done_cyc;
        logic [10:0] r;
        logic [7:0]  exp_q;
        logic [10:0] exp_rem;
        logic [3:0]  dg;

        good = (b[7:6] == 2'b01);
        qv   = 0;
        ill  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dg = digs[15-4*i -: 4];
            case (dg)
                4'b1000: dd = 2;
                4'b0100: dd = 1;
                4'b0000: dd = 0;
                4'b0010: dd = -1;
                4'b0001: dd = -2;
                default: begin dd = 0; ill = 1'b1; end
            endcase
            qv = qv * 4 + dd;
        end
        r = s + c;
        if (!good) begin
            exp_q   = 8'hFF;
            exp_rem = {3'b000, a};
            ill     = 1'b1;
        end else if (r[10]) begin
            exp_q   = 8'((qv - 1) & 255);
            exp_rem = r + {3'b000, b};
        end else begin
            exp_q   = 8'(qv & 255);
            exp_rem = r;
        end
        done_cyc = good ? ITER + 2 : 0;

        start = 1'b1;
        op1   = a;
        op2   = b;
        @(posedge clk);
        for (int cyc = 0; cyc <= done_cyc + 1; cyc++) begin
            #1;
            start  = (noise && cyc <= done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            op1    = 8'($urandom);
            op2    = 8'($urandom);
            qdigit = (cyc >= 1 && cyc <= ITER) ? digs[15-4*(cyc-1) -: 4] : 4'($urandom);
            sum    = (cyc == ITER + 1) ? s : 11'($urandom);
            carry  = (cyc == ITER + 1) ? c : 11'($urandom);
            @(negedge clk);
            chk("done", 32'(done), 32'(cyc == done_cyc));
            chk("state0", 32'(state0), 32'(good && cyc == 0));
            chk("ready", 32'(ready), 32'(cyc > done_cyc));
            if (cyc == done_cyc) begin
                chk("q", 32'(q), 32'(exp_q));
                chk("rem", 32'(rem), 32'(exp_rem));
                chk("err", 32'(err), 32'(ill));
                chk("dive", 32'(dive), 32'(a));
                chk("divi", 32'(divi), 32'(b));
            end
            if (cyc <= done_cyc) @(posedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [3:0]  legal [5];
        logic [15:0] digs;
        logic [7:0]  a;
        logic [7:0]  b;

        legal[0] = 4'b1000; legal[1] = 4'b0100; legal[2] = 4'b0000;
        legal[3] = 4'b0010; legal[4] = 4'b0001;

        rst_n = 1'b0; start = 1'b0; op1 = '0; op2 = '0;
        qdigit = '0; sum = '0; carry = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_state0", 32'(state0), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        rst_n = 1'b1;

        // Directed cases from the plan, then back-to-back with the ignored-start noise on
        run_div(8'h64, 8'h50, 16'h8204, 11'h010, 11'h005, 1'b0);
        run_div(8'h64, 8'h50, 16'h8204, 11'h7F0, 11'h000, 1'b0);
        run_div(8'h64, 8'h20, 16'h8204, 11'h010, 11'h005, 1'b0);
        run_div(8'h64, 8'h50, 16'h8C04, 11'h010, 11'h005, 1'b0);
        run_div(8'h64, 8'h50, 16'h8204, 11'h010, 11'h005, 1'b1);

        // Mid-run reset during the third ITER cycle
        start = 1'b1; op1 = 8'h9A; op2 = 8'h5B;
        @(posedge clk);
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            start  = (cyc == 1);
            qdigit = 4'b1000;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_state0", 32'(state0), 32'd0);
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_rem", 32'(rem), 32'd0);
        chk("mid_rst_dive", 32'(dive), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end
        run_div(8'h64, 8'h50, 16'h8204, 11'h7F0, 11'h000, 1'b0);

        // Randomized divides, mostly legal digits and normalized divisors
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {2'b01, 6'($urandom)};
            for (int i = 0; i < 4; i++) begin
                digs[15-4*i -: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                                                : legal[$urandom_range(0, 4)];
            end
            run_div(a, b, digs, 11'($urandom), 11'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
